// File: rtl/mem_access_master.sv
// Load/store initiator for the byte-addressed little-endian data memory: range-checks one
// request at a time, drives the memory port, extends load data. Optional macro: MISALIGN_SPLIT_EN.
module mem_access_master #(
    parameter int unsigned MEM_SIZE = 1024
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [63:0] req_addr,
    input  logic [3:0]  req_size,
    input  logic        req_signed,
    input  logic [63:0] req_wdata,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [63:0] resp_rdata,
    output logic        resp_err,
    output logic [63:0] mem_address,
    output logic        mem_write_enable,
    output logic        mem_read_enable,
    output logic [63:0] mem_write_data,
    output logic [3:0]  mem_xfer_size,
    input  logic [63:0] mem_read_data
);

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        RESP
    } state_e;

    state_e      state_q, state_d;
    logic [63:0] addr_q, addr_d;
    logic [63:0] wdata_q, wdata_d;
    logic [63:0] data_q, data_d;
    logic [3:0]  size_q, size_d;
    logic [3:0]  beat_q, beat_d;
    logic        write_q, write_d;
    logic        signed_q, signed_d;
    logic        err_q, err_d;
    logic        split_q, split_d;

    logic        size_ok;
    logic        out_of_range;
    logic        misaligned;
    logic [64:0] end_addr;
    logic        beat_last;
    logic [63:0] assembled;

    function automatic logic [63:0] extend(input logic [63:0] raw, input logic [3:0] size,
                                           input logic sgn);
        case (size)
            4'd1:    extend = {{56{sgn & raw[7]}},  raw[7:0]};
            4'd2:    extend = {{48{sgn & raw[15]}}, raw[15:0]};
            4'd4:    extend = {{32{sgn & raw[31]}}, raw[31:0]};
            default: extend = raw;
        endcase
    endfunction

    // The end address is formed in 65 bits so an address near 2^64 cannot wrap into range.
    always_comb begin
        size_ok      = (req_size == 4'd1) || (req_size == 4'd2) ||
                       (req_size == 4'd4) || (req_size == 4'd8);
        end_addr     = {1'b0, req_addr} + {61'b0, req_size};
        out_of_range = end_addr > 65'(MEM_SIZE);
        misaligned   = (req_addr[3:0] & (req_size - 4'd1)) != 4'd0;
    end

    always_comb begin
        beat_last = split_q ? (beat_q == size_q - 4'd1) : 1'b1;
        assembled = split_q ? (data_q | ({56'b0, mem_read_data[7:0]} << {beat_q, 3'b000}))
                            : mem_read_data;
    end

    // NOTE: every variable gets its hold value first, so no path through the case can infer a latch.
    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        data_d   = data_q;
        size_d   = size_q;
        beat_d   = beat_q;
        write_d  = write_q;
        signed_d = signed_q;
        err_d    = err_q;
        split_d  = split_q;

        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    addr_d   = req_addr;
                    wdata_d  = req_wdata;
                    size_d   = req_size;
                    write_d  = req_write;
                    signed_d = req_signed;
                    data_d   = '0;
                    beat_d   = '0;
                    err_d    = !size_ok || out_of_range;
`ifdef MISALIGN_SPLIT_EN
                    split_d  = size_ok && misaligned;
`else
                    split_d  = 1'b0;
                    err_d    = err_d || misaligned;
`endif
                    state_d  = err_d ? RESP : ACCESS;
                end
            end
            ACCESS: begin
                if (!write_q) begin
                    data_d = beat_last ? extend(assembled, size_q, signed_q) : assembled;
                end
                if (beat_last) begin
                    state_d = RESP;
                end else begin
                    beat_d = beat_q + 4'd1;
                end
            end
            RESP: begin
                if (resp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so all flops sample the same pre-edge values.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= IDLE;
            addr_q   <= '0;
            wdata_q  <= '0;
            data_q   <= '0;
            size_q   <= 4'd8;
            beat_q   <= '0;
            write_q  <= 1'b0;
            signed_q <= 1'b0;
            err_q    <= 1'b0;
            split_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            data_q   <= data_d;
            size_q   <= size_d;
            beat_q   <= beat_d;
            write_q  <= write_d;
            signed_q <= signed_d;
            err_q    <= err_d;
            split_q  <= split_d;
        end
    end

    // Memory port is decoded from registered state only; split beats move one byte each.
    always_comb begin
        mem_address      = '0;
        mem_write_enable = 1'b0;
        mem_read_enable  = 1'b0;
        mem_write_data   = '0;
        mem_xfer_size    = 4'd8;
        if (state_q == ACCESS) begin
            mem_write_enable = write_q;
            mem_read_enable  = !write_q;
            if (split_q) begin
                mem_address    = addr_q + {60'b0, beat_q};
                mem_xfer_size  = 4'd1;
                mem_write_data = {56'b0, wdata_q[{beat_q, 3'b000} +: 8]};
            end else begin
                mem_address    = addr_q;
                mem_xfer_size  = size_q;
                mem_write_data = wdata_q;
            end
        end
    end

    always_comb begin
        req_ready  = (state_q == IDLE);
        resp_valid = (state_q == RESP);
        resp_err   = resp_valid && err_q;
        resp_rdata = resp_valid ? data_q : '0;
    end

endmodule

// File: tb/tb_mem_access_master.sv
// Self-checking bench for mem_access_master: byte-array memory model, directed and random
// requests scored against a reference computed from the load/store rules.
module tb_mem_access_master;

    localparam int unsigned MEM_SIZE = 1024;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        req_valid, req_ready, req_write, req_signed;
    logic [63:0] req_addr, req_wdata;
    logic [3:0]  req_size;
    logic        resp_valid, resp_ready, resp_err;
    logic [63:0] resp_rdata;
    logic [63:0] mem_address, mem_write_data, mem_read_data;
    logic        mem_write_enable, mem_read_enable;
    logic [3:0]  mem_xfer_size;

    int n_tests = 0;
    int n_fail  = 0;

    logic [7:0]  sim_mem [0:MEM_SIZE-1];
    logic [7:0]  ref_mem [0:MEM_SIZE-1];
    logic [63:0] log_addr [0:255];
    logic [3:0]  log_size [0:255];
    int          ev_cnt = 0;
    int          wr_cnt = 0;

    always #5 clk = ~clk;

    mem_access_master #(.MEM_SIZE(MEM_SIZE)) dut (
        .clk              (clk),
        .reset_n          (reset_n),
        .req_valid        (req_valid),
        .req_ready        (req_ready),
        .req_write        (req_write),
        .req_addr         (req_addr),
        .req_size         (req_size),
        .req_signed       (req_signed),
        .req_wdata        (req_wdata),
        .resp_valid       (resp_valid),
        .resp_ready       (resp_ready),
        .resp_rdata       (resp_rdata),
        .resp_err         (resp_err),
        .mem_address      (mem_address),
        .mem_write_enable (mem_write_enable),
        .mem_read_enable  (mem_read_enable),
        .mem_write_data   (mem_write_data),
        .mem_xfer_size    (mem_xfer_size),
        .mem_read_data    (mem_read_data)
    );

    // Target memory: combinational read, write on posedge, every enabled beat logged.
    always_comb begin
        mem_read_data = '0;
        for (int i = 0; i < 8; i++) begin
            if (mem_address < 64'(MEM_SIZE - i))
                mem_read_data[8*i +: 8] = sim_mem[mem_address[9:0] + 10'(i)];
        end
    end

    always @(posedge clk) begin
        if (mem_write_enable) begin
            for (int i = 0; i < 8; i++) begin
                if (i < int'(mem_xfer_size) && mem_address < 64'(MEM_SIZE - i))
                    sim_mem[mem_address[9:0] + 10'(i)] <= mem_write_data[8*i +: 8];
            end
            wr_cnt <= wr_cnt + 1;
        end
        if (mem_write_enable || mem_read_enable) begin
            log_addr[ev_cnt % 256] <= mem_address;
            log_size[ev_cnt % 256] <= mem_xfer_size;
            ev_cnt <= ev_cnt + 1;
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic scramble_req();
        req_write  = 1'($urandom);
        req_addr   = {$urandom, $urandom};
        req_size   = 4'($urandom);
        req_signed = 1'($urandom);
        req_wdata  = {$urandom, $urandom};
    endtask

    task automatic wait_ready();
        int guard = 0;
        while (!req_ready && guard < 20) begin
            @(posedge clk); #1;
            guard++;
        end
        check("req_ready_before_req", {63'b0, req_ready}, 64'd1);
    endtask

    // One full transaction; the expected outcome is derived from the request rules alone.
    task automatic do_req(input logic wr, input logic [63:0] addr, input logic [3:0] size,
                          input logic sgn, input logic [63:0] wdata, input int hold);
        logic [64:0] endp;
        logic        exp_err, split;
        logic [63:0] exp_rdata, obs_rdata;
        logic        obs_err;
        int          exp_lat, exp_beats, lat, base_ev, base_wr;

        endp    = {1'b0, addr} + 65'(size);
        exp_err = !(size == 1 || size == 2 || size == 4 || size == 8) || endp > 65'(MEM_SIZE);
        split   = 1'b0;
        if (!exp_err && (addr % 64'(size)) != 0) begin
`ifdef MISALIGN_SPLIT_EN
            split = 1'b1;
`else
            exp_err = 1'b1;
`endif
        end
        exp_rdata = '0;
        if (!exp_err) begin
            if (wr) begin
                for (int i = 0; i < int'(size); i++)
                    ref_mem[addr[9:0] + 10'(i)] = wdata[8*i +: 8];
            end else begin
                for (int i = 0; i < int'(size); i++)
                    exp_rdata[8*i +: 8] = ref_mem[addr[9:0] + 10'(i)];
                if (sgn && size < 8 && exp_rdata[8*int'(size)-1])
                    exp_rdata = exp_rdata | ~((64'd1 << (8*int'(size))) - 64'd1);
            end
        end
        exp_lat   = exp_err ? 1 : (split ? 1 + int'(size) : 2);
        exp_beats = exp_err ? 0 : (split ? int'(size) : 1);

        wait_ready();
        base_ev    = ev_cnt;
        base_wr    = wr_cnt;
        req_valid  = 1'b1;
        req_write  = wr;
        req_addr   = addr;
        req_size   = size;
        req_signed = sgn;
        req_wdata  = wdata;
        @(posedge clk); #1;
        req_valid = (hold > 0);
        scramble_req();

        lat = 1;
        while (!resp_valid && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        check("latency", 64'(lat), 64'(exp_lat));
        check("resp_err", {63'b0, resp_err}, {63'b0, exp_err});
        check("resp_rdata", resp_rdata, exp_rdata);
        check("beats", 64'(ev_cnt - base_ev), 64'(exp_beats));
        check("write_beats", 64'(wr_cnt - base_wr), wr ? 64'(exp_beats) : 64'd0);
        for (int k = 0; k < exp_beats; k++) begin
            check("beat_addr", log_addr[(base_ev + k) % 256], split ? addr + 64'(k) : addr);
            check("beat_size", {60'b0, log_size[(base_ev + k) % 256]}, split ? 64'd1 : {60'b0, size});
        end

        obs_rdata = resp_rdata;
        obs_err   = resp_err;
        for (int h = 0; h < hold; h++) begin
            scramble_req();
            @(posedge clk); #1;
            check("hold_valid", {63'b0, resp_valid}, 64'd1);
            check("hold_rdata", resp_rdata, obs_rdata);
            check("hold_err", {63'b0, resp_err}, {63'b0, obs_err});
            check("hold_req_ready", {63'b0, req_ready}, 64'd0);
        end

        resp_ready = 1'b1;
        @(posedge clk); #1;
        resp_ready = 1'b0;
        req_valid  = 1'b0;
        check("resp_valid_drop", {63'b0, resp_valid}, 64'd0);
        check("ready_after_resp", {63'b0, req_ready}, 64'd1);
        if (hold > 0) check("no_extra_beats", 64'(ev_cnt - base_ev), 64'(exp_beats));
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_req_ready"}, {63'b0, req_ready}, 64'd1);
        check({tag, "_resp_valid"}, {63'b0, resp_valid}, 64'd0);
        check({tag, "_resp_err"}, {63'b0, resp_err}, 64'd0);
        check({tag, "_resp_rdata"}, resp_rdata, 64'd0);
        check({tag, "_enables"}, {62'b0, mem_write_enable, mem_read_enable}, 64'd0);
        check({tag, "_mem_address"}, mem_address, 64'd0);
        check({tag, "_mem_wdata"}, mem_write_data, 64'd0);
        check({tag, "_mem_xfer"}, {60'b0, mem_xfer_size}, 64'd8);
    endtask

    initial begin
        int bad_bytes;
        logic [3:0] rsize;
        logic [63:0] raddr;

        for (int i = 0; i < int'(MEM_SIZE); i++) begin
            sim_mem[i] = 8'h00;
            ref_mem[i] = 8'h00;
        end
        reset_n    = 1'b0;
        req_valid  = 1'b0;
        resp_ready = 1'b0;
        req_write  = 1'b0;
        req_addr   = '0;
        req_size   = 4'd0;
        req_signed = 1'b0;
        req_wdata  = '0;
        repeat (3) @(posedge clk);
        #1;
        check_idle_outputs("reset");
        reset_n = 1'b1;
        @(posedge clk); #1;

        // Aligned doubleword store and read-back.
        do_req(1'b1, 64'h10, 4'd8, 1'b0, 64'h8877665544332211, 0);
        do_req(1'b0, 64'h10, 4'd8, 1'b1, 64'h0, 0);
        // Byte loads with sign/zero extension.
        do_req(1'b0, 64'h11, 4'd1, 1'b1, 64'h0, 0);
        do_req(1'b1, 64'h20, 4'd1, 1'b0, 64'h80, 0);
        do_req(1'b0, 64'h20, 4'd1, 1'b1, 64'h0, 0);
        do_req(1'b0, 64'h20, 4'd1, 1'b0, 64'h0, 0);
        // Rejected requests: past the end, bad size, wrapping address.
        do_req(1'b0, 64'h3FC, 4'd8, 1'b0, 64'h0, 0);
        do_req(1'b0, 64'h10, 4'd3, 1'b0, 64'h0, 0);
        do_req(1'b0, 64'hFFFF_FFFF_FFFF_FFF8, 4'd8, 1'b0, 64'h0, 0);
        do_req(1'b1, 64'h3F8, 4'd8, 1'b0, 64'h1122334455667788, 0);
        // Misaligned word store and read-back.
        do_req(1'b1, 64'h13, 4'd4, 1'b0, 64'hDDCCBBAA, 0);
        do_req(1'b0, 64'h13, 4'd4, 1'b0, 64'h0, 0);
        // Response held off for five cycles with a competing request on the bus.
        do_req(1'b0, 64'h10, 4'd8, 1'b0, 64'h0, 5);

`ifdef MISALIGN_SPLIT_EN
        // Reset during the third beat of a split store: first two bytes land, no response.
        wait_ready();
        req_valid  = 1'b1;
        req_write  = 1'b1;
        req_addr   = 64'h31;
        req_size   = 4'd4;
        req_signed = 1'b0;
        req_wdata  = 64'h44332211;
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("split_beat2_we", {63'b0, mem_write_enable}, 64'd1);
        check("split_beat2_addr", mem_address, 64'h33);
        #2 reset_n = 1'b0;
        #1;
        check_idle_outputs("midreset");
        ref_mem[10'h31] = 8'h11;
        ref_mem[10'h32] = 8'h22;
        @(posedge clk); #1;
        reset_n = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(posedge clk); #1;
            check("post_reset_no_resp", {63'b0, resp_valid}, 64'd0);
        end
`else
        do_req(1'b1, 64'h31, 4'd4, 1'b0, 64'h44332211, 0);
`endif

        // Random mix of loads and stores, mostly in a small window so loads see stored data.
        for (int t = 0; t < 40; t++) begin
            case ($urandom_range(0, 9))
                0:       rsize = 4'($urandom);
                default: rsize = 4'd1 << $urandom_range(0, 3);
            endcase
            case ($urandom_range(0, 9))
                0:       raddr = 64'(MEM_SIZE) - 64'($urandom_range(1, 16));
                1:       raddr = {$urandom, $urandom};
                default: raddr = 64'($urandom_range(0, 63));
            endcase
            do_req(1'($urandom), raddr, rsize, 1'($urandom), {$urandom, $urandom},
                   ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0);
        end

        bad_bytes = 0;
        for (int i = 0; i < int'(MEM_SIZE); i++)
            if (sim_mem[i] !== ref_mem[i]) bad_bytes++;
        check("memory_image_bad_bytes", 64'(bad_bytes), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
